// File: rtl/tailight_decoder.sv
// Receive-side checker for the tail-light sequencer: decodes mode, counts sweeps, flags illegal sequences.
// Define TAILIGHT_DEC_HOLD_CHECK_EN to treat a long run of identical non-zero samples as an error.
module tailight_decoder #(
  parameter int IDLE_SAMPLES = 8,
  parameter int ERR_W        = 8,
  parameter int MAX_HOLD     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [3:0]       left_tail,
  input  logic [3:0]       right_tail,
  output logic [1:0]       mode,
  output logic             sweep_done,
  output logic             seq_err,
  output logic [ERR_W-1:0] sweep_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HAZ   = 2'b11
  } mode_e;

  localparam logic [7:0] IDLE_TH  = 8'(IDLE_SAMPLES);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
`ifdef TAILIGHT_DEC_HOLD_CHECK_EN
  localparam bit HOLD_CHECK = 1'b1;
`else
  localparam bit HOLD_CHECK = 1'b0;
`endif

  function automatic logic [3:0] sweep_pat(input logic [2:0] idx);
    case (idx)
      3'd1:    sweep_pat = 4'b0001;
      3'd2:    sweep_pat = 4'b0011;
      3'd3:    sweep_pat = 4'b0111;
      3'd4:    sweep_pat = 4'b1111;
      default: sweep_pat = 4'b0000;
    endcase
  endfunction

  mode_e            mode_q, mode_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       off_q, off_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       prev_l_q, prev_l_d;
  logic [3:0]       prev_r_q, prev_r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic       all_off, same, bad, fin;
  logic [3:0] lane, other;

  always_comb begin
    mode_d      = mode_q;
    step_d      = step_q;
    off_d       = off_q;
    hold_d      = hold_q;
    prev_l_d    = prev_l_q;
    prev_r_d    = prev_r_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sweep_cnt_d = sweep_cnt_q;
    err_cnt_d   = err_cnt_q;
    all_off     = (left_tail == 4'h0) && (right_tail == 4'h0);
    same        = (left_tail == prev_l_q) && (right_tail == prev_r_q);
    bad         = 1'b0;
    fin         = 1'b0;
    lane        = 4'h0;
    other       = 4'h0;

    if (sample_en) begin
      prev_l_d = left_tail;
      prev_r_d = right_tail;
      if (all_off) begin
        if (off_q != 8'hFF) off_d = off_q + 8'd1;
      end else begin
        off_d = 8'd0;
      end

      // Hold-run length counts the current sample, so the limit trips on run MAX_HOLD+1.
      if (all_off) begin
        hold_d = 8'd0;
      end else if (!same) begin
        hold_d = 8'd1;
      end else begin
        if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
        if (HOLD_CHECK && (hold_q >= HOLD_LIM)) bad = 1'b1;
      end

      if (!same) begin
        case (mode_q)
          MODE_IDLE: begin
            if (left_tail == 4'b0001 && right_tail == 4'h0) begin
              mode_d = MODE_LEFT;
              step_d = 3'd1;
            end else if (left_tail == 4'h0 && right_tail == 4'b0001) begin
              mode_d = MODE_RIGHT;
              step_d = 3'd1;
            end else if (left_tail == 4'hF && right_tail == 4'hF &&
                         prev_l_q == 4'h0 && prev_r_q == 4'h0) begin
              mode_d = MODE_HAZ;
              fin    = 1'b1;
            end else if (!all_off) begin
              bad = 1'b1;
            end
          end
          MODE_LEFT, MODE_RIGHT: begin
            lane  = (mode_q == MODE_LEFT) ? left_tail : right_tail;
            other = (mode_q == MODE_LEFT) ? right_tail : left_tail;
            if (other != 4'h0) begin
              bad = 1'b1;
            end else if (step_q == 3'd4) begin
              if (lane == 4'h0) begin
                fin    = 1'b1;
                step_d = 3'd0;
              end else begin
                bad = 1'b1;
              end
            end else if (lane == sweep_pat(step_q + 3'd1)) begin
              step_d = step_q + 3'd1;
            end else begin
              bad = 1'b1;
            end
          end
          default: begin
            if (left_tail == 4'hF && right_tail == 4'hF) fin = 1'b1;
            else if (!all_off) bad = 1'b1;
          end
        endcase
      end

      if (bad) begin
        err_d  = 1'b1;
        mode_d = MODE_IDLE;
        step_d = 3'd0;
        hold_d = 8'd0;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      if (fin) begin
        done_d      = 1'b1;
        sweep_cnt_d = sweep_cnt_q + ERR_W'(1);
      end
      // A long enough dark run drops back to IDLE even if a sweep just completed.
      if (!bad && (off_d >= IDLE_TH)) begin
        mode_d = MODE_IDLE;
        step_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_IDLE;
      step_q      <= 3'd0;
      off_q       <= 8'd0;
      hold_q      <= 8'd0;
      prev_l_q    <= 4'h0;
      prev_r_q    <= 4'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sweep_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      step_q      <= step_d;
      off_q       <= off_d;
      hold_q      <= hold_d;
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sweep_cnt_q <= sweep_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mode        = mode_q;
  assign sweep_done  = done_q;
  assign seq_err     = err_q;
  assign sweep_count = sweep_cnt_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_tailight_decoder.sv
// Directed bench for tailight_decoder: rule-level model compared every cycle, plus literal anchors.
module tb_tailight_decoder;
  localparam int IDLE_SAMPLES = 8;
  localparam int ERR_W        = 8;
  localparam int MAX_HOLD     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic [3:0]       left_tail, right_tail;
  logic [1:0]       mode;
  logic             sweep_done, seq_err;
  logic [ERR_W-1:0] sweep_count, err_count;

  tailight_decoder #(
    .IDLE_SAMPLES(IDLE_SAMPLES), .ERR_W(ERR_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .left_tail(left_tail), .right_tail(right_tail),
    .mode(mode), .sweep_done(sweep_done), .seq_err(seq_err),
    .sweep_count(sweep_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // model state: mode 0 idle, 1 left, 2 right, 3 hazard; pos is the index into the sweep table
  logic [3:0] sweep_tab [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
  int m_mode, m_pos, m_off, m_hold, m_sc, m_ec;
  bit m_done, m_err;
  logic [3:0] m_pl, m_pr;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input int got_dut, input int got_model, input int exp);
    chk({name, "_dut"}, got_dut, exp);
    chk({name, "_model"}, got_model, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_off = 0; m_hold = 0; m_sc = 0; m_ec = 0;
    m_done = 0; m_err = 0; m_pl = 4'h0; m_pr = 4'h0;
  endtask

  task automatic model_sample(input logic [3:0] l, input logic [3:0] r);
    bit bad, fin, off, changed;
    logic [3:0] lane, other;
    bad = 0; fin = 0;
    off = (l == 4'h0) && (r == 4'h0);
    changed = (l != m_pl) || (r != m_pr);
    m_off = off ? ((m_off < 255) ? m_off + 1 : 255) : 0;
`ifdef TAILIGHT_DEC_HOLD_CHECK_EN
    if (!off && !changed) begin
      m_hold++;
      if (m_hold > MAX_HOLD) bad = 1;
    end else begin
      m_hold = off ? 0 : 1;
    end
`endif
    if (changed) begin
      case (m_mode)
        0: begin
          if (l == 4'd1 && r == 4'd0) begin m_mode = 1; m_pos = 1; end
          else if (l == 4'd0 && r == 4'd1) begin m_mode = 2; m_pos = 1; end
          else if (l == 4'd15 && r == 4'd15 && m_pl == 4'd0 && m_pr == 4'd0) begin
            m_mode = 3; fin = 1;
          end
          else if (!off) bad = 1;
        end
        1, 2: begin
          lane  = (m_mode == 1) ? l : r;
          other = (m_mode == 1) ? r : l;
          if (other != 4'd0) bad = 1;
          else if (lane == sweep_tab[(m_pos + 1) % 5]) begin
            m_pos = (m_pos + 1) % 5;
            if (m_pos == 0) fin = 1;
          end
          else bad = 1;
        end
        default: begin
          if (l == r && (l == 4'd15 || l == 4'd0)) begin
            if (l == 4'd15) fin = 1;
          end
          else bad = 1;
        end
      endcase
    end
    m_err = bad;
    m_done = fin;
    if (bad) begin
      m_mode = 0; m_pos = 0; m_hold = 0;
      if (m_ec < 255) m_ec++;
    end
    if (fin) m_sc = (m_sc + 1) % 256;
    if (!bad && m_off >= IDLE_SAMPLES) begin m_mode = 0; m_pos = 0; end
    m_pl = l; m_pr = r;
  endtask

  // drivers: inputs change on the falling edge, DUT samples on the rising edge
  task automatic smp(input logic [3:0] l, input logic [3:0] r);
    sample_en = 1'b1; left_tail = l; right_tail = r;
    @(posedge clk);
    model_sample(l, r);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample_en  = 1'b0;
      left_tail  = 4'($urandom_range(0, 15));
      right_tail = 4'($urandom_range(0, 15));
      @(posedge clk);
      m_done = 0; m_err = 0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [3:0] l, input logic [3:0] r);
    rst = 1'b1; sample_en = 1'b1; left_tail = l; right_tail = r;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard: every cycle after reset the outputs must match the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("mode", int'(mode), m_mode);
      chk("sweep_done", int'(sweep_done), int'(m_done));
      chk("seq_err", int'(seq_err), int'(m_err));
      chk("sweep_count", int'(sweep_count), m_sc);
      chk("err_count", int'(err_count), m_ec);
    end
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; left_tail = 4'h0; right_tail = 4'h0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    lit("rst_mode", int'(mode), m_mode, 0);
    lit("rst_sc", int'(sweep_count), m_sc, 0);
    lit("rst_ec", int'(err_count), m_ec, 0);

    // left sweep, then dark run back to idle
    smp(4'b0001, 4'b0000);
    lit("left_mode", int'(mode), m_mode, 1);
    smp(4'b0011, 4'b0000);
    smp(4'b0111, 4'b0000);
    smp(4'b1111, 4'b0000);
    smp(4'b0000, 4'b0000);
    lit("left_done", int'(sweep_done), int'(m_done), 1);
    lit("left_sc", int'(sweep_count), m_sc, 1);
    lit("left_ec", int'(err_count), m_ec, 0);
    for (int i = 0; i < 6; i++) smp(4'b0000, 4'b0000);
    lit("offrun7_mode", int'(mode), m_mode, 1);
    smp(4'b0000, 4'b0000);
    lit("offrun8_mode", int'(mode), m_mode, 0);

    // hazard
    do_reset(4'h0, 4'h0);
    smp(4'b0000, 4'b0000);
    smp(4'b1111, 4'b1111);
    smp(4'b0000, 4'b0000);
    smp(4'b1111, 4'b1111);
    lit("haz_mode", int'(mode), m_mode, 3);
    lit("haz_sc", int'(sweep_count), m_sc, 2);
    for (int i = 0; i < 7; i++) smp(4'b0000, 4'b0000);
    lit("haz_off7_mode", int'(mode), m_mode, 3);
    smp(4'b0000, 4'b0000);
    lit("haz_off8_mode", int'(mode), m_mode, 0);
    smp(4'b1111, 4'b1111);
    smp(4'b1111, 4'b0000);
    lit("haz_bad_err", int'(seq_err), int'(m_err), 1);

    // right sweep, restart, then illegal skip at step 2
    do_reset(4'h0, 4'h0);
    smp(4'b0000, 4'b0001);
    smp(4'b0000, 4'b0011);
    smp(4'b0000, 4'b0111);
    smp(4'b0000, 4'b1111);
    smp(4'b0000, 4'b0000);
    lit("right_sc", int'(sweep_count), m_sc, 1);
    lit("right_mode", int'(mode), m_mode, 2);
    smp(4'b0000, 4'b0001);
    smp(4'b0000, 4'b0011);
    smp(4'b0000, 4'b1111);
    lit("right_bad_err", int'(seq_err), int'(m_err), 1);
    lit("right_bad_ec", int'(err_count), m_ec, 1);
    lit("right_bad_mode", int'(mode), m_mode, 0);
    smp(4'b0001, 4'b0000);
    lit("resume_mode", int'(mode), m_mode, 1);

    // abort mid-sweep, hazard start from non-dark, error saturation
    do_reset(4'h0, 4'h0);
    smp(4'b0001, 4'b0000);
    smp(4'b0011, 4'b0000);
    smp(4'b0000, 4'b0000);
    lit("abort_err", int'(seq_err), int'(m_err), 1);
    lit("abort_mode", int'(mode), m_mode, 0);
    smp(4'b0010, 4'b0000);
    smp(4'b1111, 4'b1111);
    lit("haz_from_lit_ec", int'(err_count), m_ec, 3);
    for (int i = 0; i < 300; i++) smp((i % 2 == 0) ? 4'b0010 : 4'b0100, 4'b0000);
    lit("sat_ec", int'(err_count), m_ec, 255);
    lit("sat_err", int'(seq_err), int'(m_err), 1);

    // sample_en low holds everything, then reset mid-sweep
    do_reset(4'h0, 4'h0);
    smp(4'b0001, 4'b0000);
    smp(4'b0011, 4'b0000);
    idle_cycles(10);
    lit("hold_en_mode", int'(mode), m_mode, 1);
    lit("hold_en_ec", int'(err_count), m_ec, 0);
    smp(4'b0111, 4'b0000);
    lit("after_en_err", int'(seq_err), int'(m_err), 0);
    smp(4'b1111, 4'b0000);
    smp(4'b0000, 4'b0000);
    smp(4'b0001, 4'b0000);
    do_reset(4'b0011, 4'b0000);
    lit("midrst_mode", int'(mode), m_mode, 0);
    lit("midrst_sc", int'(sweep_count), m_sc, 0);
    lit("midrst_done", int'(sweep_done), int'(m_done), 0);

    // repeated identical non-zero samples
    smp(4'b0001, 4'b0000);
    smp(4'b0011, 4'b0000);
    smp(4'b0011, 4'b0000);
    smp(4'b0011, 4'b0000);
`ifdef TAILIGHT_DEC_HOLD_CHECK_EN
    lit("hold3_err", int'(seq_err), int'(m_err), 1);
    lit("hold3_ec", int'(err_count), m_ec, 1);
`else
    lit("hold3_err", int'(seq_err), int'(m_err), 0);
    lit("hold3_ec", int'(err_count), m_ec, 0);
`endif
    smp(4'b0111, 4'b0000);
    idle_cycles(2);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
